button_event_decoder: RTL and testbench

Consumes the debounced, clock-synchronous button level produced by the debounce stage and converts it into single-cycle event pulses: press, release, short press, long press and, optionally, double press. It sits directly downstream of `debounce_ckt` (its `result` drives `btn_in`) and feeds LED/control logic that needs discrete events rather than a level. It also keeps a wrapping press counter for LED display.

---
 rtl/button_event_decoder.sv | 178 +++++++++++++++++
 tb/tb_button_event_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/long event pulses plus a press counter.
// Define DOUBLE_CLICK_EN to compile in the release-to-press GAP state and the double_press event.
module button_event_decoder #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic [7:0] press_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2,
    GAP  = 2'd3
  } state_t;

  // The counter only has to reach the larger threshold, so it parks there.
  localparam int MAX_CYC = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam logic [CNT_W-1:0] SAT_VAL   = CNT_W'(MAX_CYC);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  state_t           state;
  logic             btn_q;
  logic             btn_d;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign rise      = btn_q & ~btn_d;
  assign fall      = ~btn_q & btn_d;
  assign cnt_next  = (cnt == SAT_VAL) ? cnt : cnt + CNT_W'(1);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
      btn_d <= 1'b0;
    end else begin
      btn_q <= btn_in;
      btn_d <= btn_q;
    end
  end

`ifdef DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  logic second;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      second        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_press  <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_press  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
            cnt         <= '0;
            state       <= HELD;
          end
        end
        HELD: begin
          cnt <= cnt_next;
          // A release on the threshold cycle still counts as a short click.
          if (fall) begin
            release_pulse <= 1'b1;
            if (second) begin
              double_press <= 1'b1;
              second       <= 1'b0;
              state        <= IDLE;
            end else begin
              cnt   <= '0;
              state <= GAP;
            end
          end else if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            second     <= 1'b0;
            state      <= LONG;
          end
        end
        LONG: begin
          if (fall) begin
            release_pulse <= 1'b1;
            state         <= IDLE;
          end
        end
        GAP: begin
          cnt <= cnt_next;
          if (rise) begin
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
            second      <= 1'b1;
            cnt         <= '0;
            state       <= HELD;
          end else if (cnt == GAP_LAST) begin
            short_press <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign double_press = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
            cnt         <= '0;
            state       <= HELD;
          end
        end
        HELD: begin
          cnt <= cnt_next;
          // A release on the threshold cycle still counts as a short click.
          if (fall) begin
            release_pulse <= 1'b1;
            short_press   <= 1'b1;
            state         <= IDLE;
          end else if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= LONG;
          end
        end
        LONG: begin
          if (fall) begin
            release_pulse <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: expected events are queued with their cycle
// stamp and a negedge monitor pops one whenever any event output is high.
module tb_button_event_decoder;

  localparam int LONG_CYC = 8;
  localparam int GAP_CYC  = 6;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_DBL   = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic [7:0] press_count;
  logic [1:0] state_dbg;
  logic [4:0] ev;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pc = 0;
  int   t;
  int   t2;

  button_event_decoder #(
    .LONG_CYCLES(LONG_CYC),
    .GAP_CYCLES (GAP_CYC),
    .CNT_W      (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .press_count  (press_count),
    .state_dbg    (state_dbg)
  );

  assign ev = {press_pulse, release_pulse, short_press, long_press, double_press};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expectEvent(input int c, input logic [4:0] e, input logic [7:0] n);
    exp_t x;
    x.cyc = c;
    x.ev  = e;
    x.cnt = n;
    expq.push_back(x);
  endtask

  // Called on a negedge: drive the level and hold it for n cycles.
  task automatic applyStimulus(input logic level, input int n);
    btn_in = level;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any asserted event must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (ev != 5'b0) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got ev=%b with nothing expected (cycle %0d)", ev, cyc);
      end else begin
        e = expq.pop_front();
        checkOutput("event_cycle", cyc, e.cyc);
        checkOutput("event_bits", {27'd0, ev}, {27'd0, e.ev});
        checkOutput("event_press_count", {24'd0, press_count}, {24'd0, e.cnt});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected done", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkOutput("reset_events", {27'd0, ev}, 32'd0);
    checkOutput("reset_press_count", {24'd0, press_count}, 32'd0);
    checkOutput("reset_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Short press: high 4, low 12.
    t = cyc;
    pc++;
    expectEvent(t + 2, EV_PRESS, 8'(pc));
`ifdef DOUBLE_CLICK_EN
    expectEvent(t + 6, EV_REL, 8'(pc));
    expectEvent(t + 12, EV_SHORT, 8'(pc));
`else
    expectEvent(t + 6, EV_REL | EV_SHORT, 8'(pc));
`endif
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 12);

    // Long press: high 20, long_press 8 cycles after press_pulse.
    t = cyc;
    pc++;
    expectEvent(t + 2, EV_PRESS, 8'(pc));
    expectEvent(t + 10, EV_LONG, 8'(pc));
    expectEvent(t + 22, EV_REL, 8'(pc));
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 12);

    // Threshold tie: fall lands on cnt==7, so it is short.
    t = cyc;
    pc++;
    expectEvent(t + 2, EV_PRESS, 8'(pc));
`ifdef DOUBLE_CLICK_EN
    expectEvent(t + 10, EV_REL, 8'(pc));
    expectEvent(t + 16, EV_SHORT, 8'(pc));
`else
    expectEvent(t + 10, EV_REL | EV_SHORT, 8'(pc));
`endif
    applyStimulus(1'b1, 8);
    applyStimulus(1'b0, 12);

`ifdef DOUBLE_CLICK_EN
    // Double press: high 3, low 3, high 3.
    t = cyc;
    pc++;
    expectEvent(t + 2, EV_PRESS, 8'(pc));
    expectEvent(t + 5, EV_REL, 8'(pc));
    pc++;
    expectEvent(t + 8, EV_PRESS, 8'(pc));
    expectEvent(t + 11, EV_REL | EV_DBL, 8'(pc));
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 12);

    // Gap timeout: short_press 6 cycles after release.
    t = cyc;
    pc++;
    expectEvent(t + 2, EV_PRESS, 8'(pc));
    expectEvent(t + 5, EV_REL, 8'(pc));
    expectEvent(t + 11, EV_SHORT, 8'(pc));
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 10);

    // Second press reaching long discards the pending click.
    t = cyc;
    pc++;
    expectEvent(t + 2, EV_PRESS, 8'(pc));
    expectEvent(t + 5, EV_REL, 8'(pc));
    pc++;
    expectEvent(t + 8, EV_PRESS, 8'(pc));
    expectEvent(t + 16, EV_LONG, 8'(pc));
    expectEvent(t + 28, EV_REL, 8'(pc));
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 12);
`endif

    // Reset in the middle of HELD: everything clears at once, no pulses afterwards.
    t = cyc;
    pc++;
    expectEvent(t + 2, EV_PRESS, 8'(pc));
    applyStimulus(1'b1, 4);
    checkOutput("held_before_reset", {30'd0, state_dbg}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_events", {27'd0, ev}, 32'd0);
    checkOutput("async_reset_count", {24'd0, press_count}, 32'd0);
    checkOutput("async_reset_state", {30'd0, state_dbg}, 32'd0);
    checkOutput("drained_before_reset", expq.size(), 32'd0);
    pc = 0;
    @(negedge clk);
    btn_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("idle_after_reset", {30'd0, state_dbg}, 32'd0);
    checkOutput("count_after_reset", {24'd0, press_count}, 32'd0);

    // Button held through reset release still yields a press.
    rst = 1'b1;
    btn_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t = cyc;
    pc++;
    expectEvent(t + 2, EV_PRESS, 8'(pc));
    repeat (4) @(negedge clk);
    t2 = cyc;
`ifdef DOUBLE_CLICK_EN
    expectEvent(t2 + 2, EV_REL, 8'(pc));
    expectEvent(t2 + 8, EV_SHORT, 8'(pc));
`else
    expectEvent(t2 + 2, EV_REL | EV_SHORT, 8'(pc));
`endif
    applyStimulus(1'b0, 12);

    checkOutput("queue_drained", expq.size(), 32'd0);
    checkOutput("final_state", {30'd0, state_dbg}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
